// File: rtl/pc_step_unit.sv
// rtl/pc_step_unit.sv - program counter with parametrised step, branch/jump/register targets, EPC and misalignment trap
// Exceptions and misaligned targets both vector to EXC_VECTOR; eret restores the saved PC.
module pc_step_unit #(
  parameter int WIDTH = 32,
  parameter int STEP_LOG2 = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             zero,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] branch_off,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic [WIDTH-1:0] reg_addr,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic [WIDTH-1:0] epc,
  output logic             addr_err
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1) << STEP_LOG2;

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] target;
  logic             take;
  logic             misaligned;

  assign pc_plus_step = pc + STEP;
  assign br_target    = pc_plus_step + (branch_off << STEP_LOG2);
  assign take         = pc_write | (pc_write_cond & zero);

  always_comb begin
    target = pc_plus_step;
    case (pc_src)
      2'b00:   target = pc_plus_step;
      2'b01:   target = br_target;
      2'b10:   target = jump_addr;
      default: target = reg_addr;
    endcase
  end

  // Byte-granular instruction sets have no alignment constraint.
  generate
    if (STEP_LOG2 == 0) begin : g_no_align
      assign misaligned = 1'b0;
    end else begin : g_align
      assign misaligned = |target[STEP_LOG2-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      epc      <= '0;
      addr_err <= 1'b0;
    end else if (exc) begin
      epc <= pc;
      pc  <= EXC_VECTOR;
    end else if (eret) begin
      pc       <= epc;
      addr_err <= 1'b0;
    end else if (take && misaligned) begin
      epc      <= pc;
      pc       <= EXC_VECTOR;
      addr_err <= 1'b1;
    end else if (take) begin
      pc <= target;
    end
  end

endmodule

// File: doc/pc_step_unit.md
# pc_step_unit

Parametrised program-counter block for the multi-cycle CPU. It replaces the fixed constant-4 source feeding the PC adder. It owns the PC register, the PC+STEP incrementer, and branch/jump/register target selection under the multi-cycle control unit's write enables. It also captures an exception return address (EPC), vectors on exceptions, and traps misaligned targets.

## Interface
- WIDTH, 32, address width in bits (≥ 8)
- STEP_LOG2, 2, log2 of instruction size; STEP = 1<<STEP_LOG2 (default 4)
- RESET_PC, 0, PC value after reset
- EXC_VECTOR, 32'h0000_0100, PC loaded on exception or misalignment trap (truncated to WIDTH)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_write  in  1  unconditional PC update this cycle
- pc_write_cond  in  1  conditional PC update, qualified by zero
- zero  in  1  ALU zero flag
- pc_src  in  2  00 increment, 01 branch, 10 jump, 11 register
- branch_off  in  WIDTH  signed word offset, already sign-extended
- jump_addr  in  WIDTH  absolute jump target (byte address)
- reg_addr  in  WIDTH  register-indirect target (byte address)
- exc  in  1  exception request
- eret  in  1  return from exception
- pc  out  WIDTH  current PC (registered)
- pc_plus_step  out  WIDTH  pc + STEP (combinational)
- epc  out  WIDTH  saved exception PC (registered)
- addr_err  out  1  sticky misalignment flag (registered)

## Operation
- Next-target candidates, all modulo 2^WIDTH:
  - inc = pc + STEP
  - br = pc + STEP + (branch_off << STEP_LOG2), with wrap
  - jmp = jump_addr
  - reg = reg_addr
- target = candidate selected by pc_src.
- take = pc_write | (pc_write_cond & zero).
- misaligned = target[STEP_LOG2-1:0] != 0. It is never true for inc or br when pc is aligned. When STEP_LOG2 = 0, misaligned is always 0.
- Per-cycle priority, highest first:
  1. exc: epc ← pc; pc ← EXC_VECTOR; addr_err unchanged.
  2. eret: pc ← epc; epc unchanged.
  3. take & misaligned: epc ← pc; pc ← EXC_VECTOR; addr_err ← 1.
  4. take: pc ← target.
  5. Otherwise all registers hold.
- The addr_err flag is sticky. It clears only on reset or on eret.
- If eret and take occur together, eret wins and the take is ignored.
- pc_write and pc_write_cond asserted together behave as pc_write alone.

## Timing
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC
  - epc = 0
  - addr_err = 0
  - pc_plus_step follows pc combinationally, so it equals RESET_PC + STEP during reset.
- Release of reset is sampled synchronously. The first update can occur on the first rising edge where rst_n is high.
- Single-cycle latency: the decision made on edge N is visible on pc and epc immediately after edge N.
- pc_plus_step has zero latency from pc, with no register.
- Reset asserted mid-update overrides everything; no partial state survives.
- Wrap-around: pc = 2^WIDTH − STEP with increment gives 0; there is no overflow flag.

## Test plan
- Reset and increment (WIDTH=32, STEP_LOG2=2, RESET_PC=0):
  - Hold rst_n low → pc = 0, pc_plus_step = 4.
  - Release, then pc_write=1, pc_src=00 for 3 cycles → pc = 4, 8, 12.
- Conditional branch, from pc = 0x40:
  - pc_write_cond=1, pc_src=01, branch_off=−2, zero=0 → pc stays 0x40.
  - Same with zero=1 → pc = 0x3C.
- Jump and register, with pc_write=1:
  - pc_src=10, jump_addr=0x1000 → pc = 0x1000.
  - pc_src=11, reg_addr=0x2002 → pc = EXC_VECTOR (0x100), epc = 0x1000, addr_err = 1.
- Exception and return, from pc = 0x80:
  - exc=1 with pc_write=1 in the same cycle → pc = 0x100, epc = 0x80.
  - Next cycle eret=1 → pc = 0x80, addr_err = 0.
- Wrap and width (WIDTH=16, STEP_LOG2=1):
  - pc = 0xFFFE, increment → pc = 0x0000, pc_plus_step = 0x0002.
  - Branch with branch_off=3 from pc = 0x10 → pc = 0x18.
- Asynchronous reset mid-operation: pull rst_n low between edges while pc = 0x1234 → pc = RESET_PC, epc = 0, addr_err = 0 immediately, without waiting for a clock edge.
